// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to count n chunks; never below 1 so a single-chunk build still has an index reg.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle between operand registers, adder and result consumer.
interface seq_chunk_adder_if #(parameter int WIDTH = 128);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder_chunk.sv
// One-bit full adder cell and the CHUNK-bit ripple stage built from it.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_adder #(parameter int CHUNK = 8) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  fulladd u_fa [CHUNK-1:0] (
    .a  (a),
    .b  (b),
    .ci (c[CHUNK-1:0]),
    .s  (s),
    .co (c[CHUNK:1])
  );

  assign cout  = c[CHUNK];
  // carry into the top bit of this chunk; only meaningful for the last chunk (signed overflow)
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/sub: one CHUNK-wide slice per clock, carry held in a register between slices.
// Subtraction is folded in at acceptance (b inverted, carry-in inverted) so RUN only ever adds.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_chunk_adder_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = clog2(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_chunk_adder: CHUNK must divide WIDTH");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;

  logic             accept, last;
  int               base;
  logic [CHUNK-1:0] ch_s;
  logic             ch_co, ch_cmsb;

  assign accept = (state_q == ST_IDLE) && bus.in_valid;
  assign last   = (state_q == ST_RUN) && (idx_q == LAST);
  assign base   = CHUNK * int'(idx_q);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[base +: CHUNK]),
    .b     (b_q[base +: CHUNK]),
    .cin   (carry_q),
    .s     (ch_s),
    .cout  (ch_co),
    .c_msb (ch_cmsb)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state: accept in IDLE, leave RUN after last chunk, hold DONE until consumer takes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
      ST_RUN:  if (idx_q == LAST) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // operand capture at acceptance, then one chunk per cycle into the sum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b ^ {WIDTH{bus.sub}};
      carry_q <= bus.cin ^ bus.sub;
      idx_q   <= '0;
    end else if (state_q == ST_RUN) begin
      sum_q[base +: CHUNK] <= ch_s;
      carry_q              <= ch_co;
      idx_q                <= last ? '0 : idx_q + 1'b1;
      if (last) begin
        cout_q <= ch_co;
        ovf_q  <= ch_co ^ ch_cmsb;
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: 128/8 main instance plus a 16/16 single-chunk instance.
module tb_seq_chunk_adder;
  localparam int W  = 128;
  localparam int NC = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(W))  bus ();
  seq_chunk_adder_if #(.WIDTH(16)) bus16 ();

  seq_chunk_adder #(.WIDTH(W), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  // Reference: whole-word arithmetic; returns {ovf, cout, sum}
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, b, input logic c, s);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? ~c : c)};
    ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ov, full};
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one op, scramble inputs after acceptance, wait for out_valid; lat = cycles after accept
  task automatic run_op(input logic [W-1:0] a, b, input logic c, s, output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.a = a; bus.b = b; bus.cin = c; bus.sub = s; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = rnd_word(); bus.b = rnd_word();
    bus.cin = 1'($urandom); bus.sub = 1'($urandom);
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = i; break; end
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    #12;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.cout, bus.ovf} !== 4'b1000 || bus.sum !== '0) begin
      fails++;
      $display("FAIL reset: rdy/vld/cout/ovf=%b sum=%h, want 1000 sum=0",
               {bus.in_ready, bus.out_valid, bus.cout, bus.ovf}, bus.sum);
    end
    tests++;
    if ({bus16.in_ready, bus16.out_valid} !== 2'b10 || bus16.sum !== 16'h0) begin
      fails++;
      $display("FAIL reset16: rdy/vld=%b sum=%h, want 10 sum=0",
               {bus16.in_ready, bus16.out_valid}, bus16.sum);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4], vb [4], es [4];
    logic         vc [4], vs [4], ec [4], eo [4];
    int           lat;
    va[0] = {16{8'hAA}}; vb[0] = {16{8'hCC}}; vc[0] = 0; vs[0] = 0;
    es[0] = {{15{8'h77}}, 8'h76}; ec[0] = 1; eo[0] = 1;
    va[1] = '1; vb[1] = '0; vc[1] = 1; vs[1] = 0; es[1] = '0; ec[1] = 1; eo[1] = 0;
    va[2] = W'(5); vb[2] = W'(7); vc[2] = 0; vs[2] = 1;
    es[2] = {{(W-4){1'b1}}, 4'hE}; ec[2] = 0; eo[2] = 0;
    va[3] = W'(7); vb[3] = W'(5); vc[3] = 0; vs[3] = 1; es[3] = W'(2); ec[3] = 1; eo[3] = 0;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], vs[i], lat);
      tests++;
      if (lat !== NC) begin
        fails++; $display("FAIL dir%0d latency: got %0d want %0d", i, lat, NC);
      end
      tests++;
      if ({bus.sum, bus.cout, bus.ovf} !== {es[i], ec[i], eo[i]}) begin
        fails++;
        $display("FAIL dir%0d result: sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, bus.sum, bus.cout, bus.ovf, es[i], ec[i], eo[i]);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         c, s;
    logic [W+1:0] exp;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = '1; b = rnd_word(); end
        1: begin a = rnd_word(); b = (i % 2) ? '0 : '1; end
        default: begin a = rnd_word(); b = rnd_word(); end
      endcase
      c = 1'($urandom); s = 1'($urandom);
      bus.out_ready = 1'($urandom);   // early out_ready must be harmless
      exp = ref_op(a, b, c, s);
      run_op(a, b, c, s, lat);
      tests++;
      if (lat !== NC || {bus.ovf, bus.cout, bus.sum} !== exp) begin
        fails++;
        $display("FAIL rand%0d: lat=%0d ovf/cout/sum=%b/%b/%h want lat=%0d %b/%b/%h",
                 i, lat, bus.ovf, bus.cout, bus.sum, NC, exp[W+1], exp[W], exp[W-1:0]);
      end
      release_out();
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] a, b, a2, b2;
    logic [W+1:0] exp, exp2;
    int           lat;
    a = rnd_word(); b = rnd_word();
    exp = ref_op(a, b, 1'b1, 1'b0);
    run_op(a, b, 1'b1, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom); bus.a = rnd_word(); bus.b = rnd_word();
      @(posedge clk); #1;
      tests++;
      if (!bus.out_valid || bus.in_ready || {bus.ovf, bus.cout, bus.sum} !== exp) begin
        fails++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h want vld=1 rdy=0 sum=%h",
                 i, bus.out_valid, bus.in_ready, bus.sum, exp[W-1:0]);
      end
    end
    // consumer takes result while next op is already offered: must not be accepted this edge
    a2 = rnd_word(); b2 = rnd_word();
    exp2 = ref_op(a2, b2, 1'b0, 1'b1);
    bus.a = a2; bus.b = b2; bus.cin = 1'b0; bus.sub = 1'b1; bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = rnd_word(); bus.b = rnd_word();
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = i; break; end
    end
    tests++;
    if (lat !== NC || {bus.ovf, bus.cout, bus.sum} !== exp2) begin
      fails++;
      $display("FAIL bp_next: lat=%0d sum=%h cout=%b want lat=%0d sum=%h cout=%b",
               lat, bus.sum, bus.cout, NC, exp2[W-1:0], exp2[W]);
    end
    release_out();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bus.a = rnd_word(); bus.b = rnd_word(); bus.cin = 1'b1; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== '0) begin
      fails++;
      $display("FAIL rst_mid: vld=%b rdy=%b sum=%h want vld=0 rdy=1 sum=0",
               bus.out_valid, bus.in_ready, bus.sum);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(W'(1), W'(1), 1'b0, 1'b0, lat);
    tests++;
    if (lat !== NC || bus.sum !== W'(2) || bus.cout !== 1'b0) begin
      fails++;
      $display("FAIL rst_after: lat=%0d sum=%h cout=%b want lat=%0d sum=2 cout=0",
               lat, bus.sum, bus.cout, NC);
    end
    release_out();
  endtask

  task automatic test_single_chunk();
    logic [15:0] a, b, bb, es;
    logic [16:0] full;
    logic        c, s, eo;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin a = 16'h7FFF; b = 16'h0001; c = 0; s = 0; end
      else begin a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); s = 1'($urandom); end
      bb   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {16'h0, (s ? ~c : c)};
      es   = full[15:0];
      eo   = (a[15] == bb[15]) && (es[15] != a[15]);
      bus16.a = a; bus16.b = b; bus16.cin = c; bus16.sub = s; bus16.in_valid = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (bus16.out_valid !== 1'b1 || {bus16.ovf, bus16.cout, bus16.sum} !== {eo, full}) begin
        fails++;
        $display("FAIL single%0d: vld=%b ovf=%b cout=%b sum=%h want vld=1 ovf=%b cout=%b sum=%h",
                 i, bus16.out_valid, bus16.ovf, bus16.cout, bus16.sum, eo, full[16], es);
      end
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      bus16.out_ready = 1'b0;
    end
    tests++;
    if (bus16.in_ready !== 1'b1) begin
      fails++; $display("FAIL single_idle: rdy=%b want 1", bus16.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_pressure();
    test_reset_mid_run();
    test_single_chunk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
